fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage placed directly upstream of the opcode/func decoder. It owns the program counter, fetches each instruction from instruction memory over a req/ack handshake, and holds the instruction stable so the decoder and datapath can execute it. On `advance`, it computes the next PC from the decoder's `pc_source` selection plus the branch and ALU results, then fetches the next instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, value held in the instruction register while no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held high until acked
- imem_addr  out  32  fetch address; equals pc, stable while imem_req=1
- imem_ack  in  1  memory has returned data on imem_rdata this cycle
- imem_rdata  in  32  instruction word, sampled only when imem_req & imem_ack
- instr  out  32  held instruction
- opcode  out  7  instr[6:0], to decoder
- func3  out  3  instr[14:12], to decoder
- func7  out  7  instr[31:25], to decoder
- instr_valid  out  1  instr/pc describe an instruction ready to execute
- pc  out  32  address of the held instruction
- pc_plus4  out  32  pc+4, used for the JAL/JALR link value
- advance  in  1  datapath has finished the current instruction; honoured only in HOLD
- pc_source  in  2  from decoder: 00 jalr, 01 jal, 10 branch, 11 pc+4
- branch_taken  in  1  ALU comparison result; used only when pc_source=10
- imm  in  32  sign-extended immediate (J/B offset)
- alu_result  in  32  rs1+imm, the JALR target
- fetch_fault  out  1  misaligned next-PC detected; sticky until reset

Behaviour:
- Reset values (asynchronous, applied while rst_n=0):
  - state=BOOT, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, fetch_fault=0.
- All outputs are registered or decoded directly from registered state; none depend combinationally on the inputs.
- States: BOOT, REQ, HOLD, FAULT.
- BOOT: lasts one cycle after reset release, then moves to REQ.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack: capture imem_rdata into instr, set instr_valid=1, go to HOLD next cycle.
  - Without ack: stay in REQ with address and request held. There is no timeout.
- HOLD:
  - imem_req=0; instr and pc are stable.
  - On advance, compute next_pc:
    - 00: {alu_result[31:1],1'b0}
    - 01: pc+imm
    - 10: branch_taken ? pc+imm : pc+4
    - 11: pc+4
  - If next_pc[1:0]!=0: go to FAULT, set fetch_fault=1, leave pc unchanged.
  - Otherwise: pc<=next_pc, instr_valid<=0, instr<=NOP_INSTR, go to REQ.
  - Minimum cost per instruction: one REQ cycle (when ack arrives in the first REQ cycle) plus one HOLD cycle.
- FAULT: imem_req=0, instr_valid=0, and the block stays here until reset.
- Arithmetic: all additions are modulo 2^32. pc+4 at 32'hFFFF_FFFC wraps to 0 with no fault.
- advance outside HOLD is ignored. imem_ack outside REQ is ignored.
- Reset asserted mid-REQ: imem_req drops immediately (asynchronously), and any later ack from the old request is ignored.
- pc_source, branch_taken, imm and alu_result are sampled only on the cycle where HOLD & advance.

Decomposition:
- Shared package (core_pkg):
  - pc_source encodings PC_JALR/PC_JAL/PC_BRANCH/PC_PLUS4
  - NOP_INSTR constant
  - fetch state enum
  - the instruction_t enum, moved here from the decoder file
- One sub-module, next_pc_calc: combinational mux/adder producing next_pc and a misaligned flag.

Test Plan:
- Reset with RESET_PC=0, memory acking in the same cycle with 32'h00500093 -> BOOT, then REQ addr 0, then HOLD with instr_valid=1, opcode=7'h13; advance with pc_source=11 -> next request at addr 4.
- Ack delayed 3 cycles -> imem_req and imem_addr held constant for 4 cycles; instr_valid stays 0 until the cycle after ack.
- pc=0x100 in HOLD, pc_source=10, imm=-8, branch_taken=1 -> fetch 0xF8; branch_taken=0 -> fetch 0x104.
- JALR with alu_result=0x203 -> fetch 0x202 is misaligned -> FAULT, fetch_fault=1, imem_req=0 thereafter; JAL with imm=0x10 from 0x40 -> 0x50.
- pc=0xFFFF_FFFC, advance with pc_source=11 -> next fetch at 0x0, no fault.
- rst_n pulsed low mid-REQ at pc=0x80 -> imem_req=0 during reset; after release, fetch restarts at RESET_PC; a stale ack during BOOT leaves instr=NOP_INSTR.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: pc_source encodings, fetch FSM states,
// the NOP constant and the RV32I major-opcode enum.
package core_pkg;

  localparam logic [1:0] PC_JALR   = 2'b00;
  localparam logic [1:0] PC_JAL    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_PLUS4  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_REQ   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_e;

  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6f,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_IMM    = 7'h13,
    OP_REG    = 7'h33,
    OP_FENCE  = 7'h0f,
    OP_SYSTEM = 7'h73
  } instruction_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jalr / jal / branch / sequential,
// plus a word-misalignment flag on the result.
module next_pc_calc
  import core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_source,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc_imm;
  logic [31:0] pc_seq;

  always_comb begin
    pc_imm  = pc + imm;
    pc_seq  = pc + 32'd4;
    next_pc = pc_seq;
    unique case (pc_source)
      PC_JALR:   next_pc = {alu_result[31:1], 1'b0};
      PC_JAL:    next_pc = pc_imm;
      PC_BRANCH: next_pc = branch_taken ? pc_imm : pc_seq;
      PC_PLUS4:  next_pc = pc_seq;
      default:   next_pc = pc_seq;
    endcase
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack
// and holds the instruction until the datapath advances.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic [1:0]  pc_source,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        fetch_fault
);

  import core_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;

  logic [31:0]  npc;
  logic         npc_mis;

  next_pc_calc u_next_pc (
    .pc           (pc_q),
    .pc_source    (pc_source),
    .branch_taken (branch_taken),
    .imm          (imm),
    .alu_result   (alu_result),
    .next_pc      (npc),
    .misaligned   (npc_mis)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          valid_d = 1'b0;
          if (npc_mis) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            pc_d    = npc;
            instr_d = NOP_INSTR;
            state_d = ST_REQ;
          end
        end
      end
      ST_FAULT: valid_d = 1'b0;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Request is a pure state decode so reset drops it at once
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign func3       = instr_q[14:12];
  assign func7       = instr_q[31:25];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_fault = fault_q;

endmodule
